// File: rtl/pb_debounce_multi_pkg.sv
// rtl/pb_debounce_multi_pkg.sv - shared constants and width helpers for the multi-channel debouncer
// Purpose: board clock / 1 ms tick divider default and constant-width helpers.
// Ports: none (package).
package pb_debounce_multi_pkg;

  localparam int BOARD_CLK_HZ = 50_000_000;
  localparam int DIV_1MS      = BOARD_CLK_HZ / 1000;

  // Ceiling log2; clog2(0) and clog2(1) both give 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold every value 0..n, never less than one.
  function automatic int width_of(input int n);
    int w;
    w = clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// rtl/pb_debounce_chan.sv - one debounced push-button channel
// Purpose: synchroniser, sample history, stable level, rise/fall pulses and hold auto-repeat.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : common sample strobe, one clk wide
//   btn_raw    : raw asynchronous pin
//   state      : debounced level, 1 = pressed
//   rise, fall : one-clk press / release pulses
//   rpt        : one-clk auto-repeat pulse while held
module pb_debounce_chan
  import pb_debounce_multi_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic state,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int            CW      = width_of(max2(REPEAT_DLY, REPEAT_PER));
  localparam logic          INV     = (ACTIVE_LOW != 0);
  localparam logic          RPT_EN  = (REPEAT_DLY > 0);
  localparam logic [CW-1:0] DLY_LIM = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] PER_LIM = CW'(REPEAT_PER);

  logic             sync1;
  logic             sync2;
  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] hist_next;
  logic             all_on;
  logic             all_off;
  logic [CW-1:0]    hold_cnt;
  logic [CW-1:0]    hold_lim;
  logic [CW-1:0]    cnt_inc;
  logic             rpt_hit;

  // Polarity is folded in before the synchroniser so everything downstream
  // sees 1 = pressed; reset therefore parks the flops at "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw ^ INV;
      sync2 <= sync1;
    end
  end

  // Decisions are taken on the history as it will be after this tick's shift.
  assign hist_next = {hist[DEPTH-2:0], sync2};
  assign all_on    = &hist_next;
  assign all_off   = ~|hist_next;
  assign cnt_inc   = hold_cnt + CW'(1);
  assign rpt_hit   = RPT_EN && (cnt_inc == hold_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      state    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      rpt      <= 1'b0;
      hold_cnt <= '0;
      hold_lim <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      rpt  <= 1'b0;
      if (tick) begin
        hist <= hist_next;
        if (all_on && !state) begin
          state    <= 1'b1;
          rise     <= 1'b1;
          hold_cnt <= '0;
          hold_lim <= DLY_LIM;
        end else if (all_off && state) begin
          // Release takes priority over a repeat due on the same tick.
          state    <= 1'b0;
          fall     <= 1'b1;
          hold_cnt <= '0;
        end else if (state && RPT_EN) begin
          // First repeat after REPEAT_DLY ticks, then every REPEAT_PER ticks;
          // the counter restarts at each repeat so it never passes its limit.
          if (rpt_hit) begin
            rpt      <= 1'b1;
            hold_cnt <= '0;
            hold_lim <= PER_LIM;
          end else begin
            hold_cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pb_debounce_multi.sv
// rtl/pb_debounce_multi.sv - multi-channel push-button debouncer with shared sample prescaler
// Purpose: divides clk into a sample tick and fans it out to CHANNELS debounce channels.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn_in     : raw asynchronous button pins
//   btn_state  : debounced levels, 1 = pressed
//   btn_rise   : one-clk press pulses
//   btn_fall   : one-clk release pulses
//   btn_rpt    : one-clk auto-repeat pulses while held
//   tick_out   : sample tick, one clk wide
module pb_debounce_multi
  import pb_debounce_multi_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 8,
  parameter int DIV        = DIV_1MS,
  parameter int ACTIVE_LOW = 0,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_rpt,
  output logic                tick_out
);

  localparam int            PW   = width_of(DIV - 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;

  // With DIV = 1 LAST is 0, the count never leaves 0 and the tick is
  // asserted every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (pre_cnt == LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick_out = (pre_cnt == LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pb_debounce_chan #(
      .DEPTH      (DEPTH),
      .ACTIVE_LOW (ACTIVE_LOW),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick_out),
      .btn_raw (btn_in[g]),
      .state   (btn_state[g]),
      .rise    (btn_rise[g]),
      .fall    (btn_fall[g]),
      .rpt     (btn_rpt[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb/tb_pb_debounce_multi.sv - self-checking bench for pb_debounce_multi
module tb_pb_debounce_multi;

  localparam int CH    = 4;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int DLY   = 3;
  localparam int PER   = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pin0  = '0;
  logic [CH-1:0] pin1  = '1;
  logic [CH-1:0] st0, ri0, fa0, rp0;
  logic [CH-1:0] st1, ri1, fa1, rp1;
  logic          tk0, tk1;

  int total = 0;
  int bad   = 0;

  // Reference model: prescaler phase, pin delayed through two stages,
  // run lengths of equal samples and ticks elapsed since the press.
  int p_cnt;
  bit m_tk;
  bit d1    [2][CH];
  bit d2    [2][CH];
  int ones  [2][CH];
  int zeros [2][CH];
  int held  [2][CH];
  bit m_st  [2][CH];
  bit m_ri  [2][CH];
  bit m_fa  [2][CH];
  bit m_rp  [2][CH];

  always #5 clk = ~clk;

  pb_debounce_multi #(
    .CHANNELS(CH), .DEPTH(DEPTH), .DIV(DIV), .ACTIVE_LOW(0),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(pin0), .btn_state(st0), .btn_rise(ri0),
    .btn_fall(fa0), .btn_rpt(rp0), .tick_out(tk0)
  );

  pb_debounce_multi #(
    .CHANNELS(CH), .DEPTH(DEPTH), .DIV(DIV), .ACTIVE_LOW(1),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(pin1), .btn_state(st1), .btn_rise(ri1),
    .btn_fall(fa1), .btn_rpt(rp1), .tick_out(tk1)
  );

  function automatic void model_reset();
    p_cnt = 0;
    m_tk  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        d1[i][c] = 1'b0; d2[i][c] = 1'b0;
        ones[i][c] = 0; zeros[i][c] = DEPTH; held[i][c] = 0;
        m_st[i][c] = 1'b0; m_ri[i][c] = 1'b0; m_fa[i][c] = 1'b0; m_rp[i][c] = 1'b0;
      end
    end
  endfunction

  function automatic void model_edge();
    bit tick;
    bit pressed;
    bit smp;
    tick  = (p_cnt == DIV - 1);
    p_cnt = (p_cnt + 1) % DIV;
    m_tk  = (p_cnt == DIV - 1);
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < CH; c++) begin
        pressed = (i == 0) ? bit'(pin0[c]) : !bit'(pin1[c]);
        smp = d2[i][c];
        d2[i][c] = d1[i][c];
        d1[i][c] = pressed;
        m_ri[i][c] = 1'b0; m_fa[i][c] = 1'b0; m_rp[i][c] = 1'b0;
        if (tick) begin
          if (smp) begin ones[i][c]++; zeros[i][c] = 0; end
          else begin zeros[i][c]++; ones[i][c] = 0; end
          if (ones[i][c] >= DEPTH && !m_st[i][c]) begin
            m_st[i][c] = 1'b1; m_ri[i][c] = 1'b1; held[i][c] = 0;
          end else if (zeros[i][c] >= DEPTH && m_st[i][c]) begin
            m_st[i][c] = 1'b0; m_fa[i][c] = 1'b1;
          end else if (m_st[i][c]) begin
            held[i][c]++;
            if (held[i][c] >= DLY && (held[i][c] - DLY) % PER == 0) m_rp[i][c] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Expected {state, rise, fall, rpt, tick} for one instance.
  function automatic logic [4*CH:0] exp_vec(input int i);
    logic [4*CH:0] v;
    v = '0;
    v[0] = m_tk;
    for (int c = 0; c < CH; c++) begin
      v[1 + c]        = m_rp[i][c];
      v[1 + CH + c]   = m_fa[i][c];
      v[1 + 2*CH + c] = m_ri[i][c];
      v[1 + 3*CH + c] = m_st[i][c];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    int first_tick;
    first_tick = -1;
    rst_n = 1'b0; pin0 = '0; pin1 = '1;
    #2;
    total++;
    if ({st0, ri0, fa0, rp0, tk0, st1, ri1, fa1, rp1, tk1} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {st0, ri0, fa0, rp0, tk0, st1, ri1, fa1, rp1, tk1});
    end
    model_reset();
    step(); step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (tk0 && first_tick < 0) first_tick = k;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL reset_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
      total++; if ({st1, ri1, fa1, rp1, tk1} !== exp_vec(1)) begin bad++; $display("FAIL reset_model1 got=%h exp=%h", {st1, ri1, fa1, rp1, tk1}, exp_vec(1)); end
    end
    total++;
    if (first_tick != DIV - 1) begin bad++; $display("FAIL first_tick got=%0d exp=%0d", first_tick, DIV - 1); end
  endtask

  task automatic test_clean_press();
    int rises, others;
    rises = 0; others = 0;
    pin0[0] = 1'b1;
    for (int k = 1; k <= 2 + DEPTH * DIV + 1; k++) begin
      step();
      rises += int'(ri0[0]);
      if (ri0[3:1] != 0 || st0[3:1] != 0) others++;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL press_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
      total++; if ({st1, ri1, fa1, rp1, tk1} !== exp_vec(1)) begin bad++; $display("FAIL press_model1 got=%h exp=%h", {st1, ri1, fa1, rp1, tk1}, exp_vec(1)); end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL press_rise_count got=%0d exp=1", rises); end
    total++; if (st0[0] !== 1'b1) begin bad++; $display("FAIL press_state got=%b exp=1", st0[0]); end
    total++; if (others != 0) begin bad++; $display("FAIL press_other_chan got=%0d exp=0", others); end
  endtask

  task automatic test_bounce();
    int events;
    events = 0;
    for (int k = 0; k < 80; k++) begin
      if (k < 40 && k % 5 == 0) pin0[1] = ~pin0[1];
      if (k == 40) pin0[1] = 1'b0;
      step();
      if (ri0[1] || fa0[1] || rp0[1] || st0[1]) events++;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL bounce_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    total++; if (events != 0) begin bad++; $display("FAIL bounce_events got=%0d exp=0", events); end
  endtask

  task automatic test_hold_repeat();
    bit found;
    int got_q[$];
    int exp_q[$];
    int late;
    found = 1'b0; late = 0;
    pin0[2] = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (ri0[2]) found = 1'b1;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL hold_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    total++; if (!found) begin bad++; $display("FAIL hold_rise got=none exp=pulse"); end
    for (int k = 1; k <= 12 * DIV; k++) begin
      step();
      if (rp0[2]) got_q.push_back(k);
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL hold_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    for (int t = DLY; t <= 12; t += PER) exp_q.push_back(t * DIV);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL hold_rpt_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int n = 0; n < exp_q.size(); n++) begin
        total++;
        if (got_q[n] != exp_q[n]) begin bad++; $display("FAIL hold_rpt_time got=%0d exp=%0d", got_q[n], exp_q[n]); end
      end
    end
    pin0[2] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (fa0[2]) found = 1'b1;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL release_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    total++; if (!found) begin bad++; $display("FAIL release_fall got=none exp=pulse"); end
    for (int k = 0; k < 40; k++) begin
      step();
      if (rp0[2] || fa0[2]) late++;
    end
    total++; if (late != 0) begin bad++; $display("FAIL release_after got=%0d exp=0", late); end
  endtask

  task automatic test_active_low();
    int rises;
    rises = 0;
    total++; if ({st1, ri1, fa1, rp1} !== '0) begin bad++; $display("FAIL al_idle got=%h exp=0", {st1, ri1, fa1, rp1}); end
    pin1[3] = 1'b0;
    for (int k = 1; k <= 2 + DEPTH * DIV + 1; k++) begin
      step();
      rises += int'(ri1[3]);
      total++; if ({st1, ri1, fa1, rp1, tk1} !== exp_vec(1)) begin bad++; $display("FAIL al_model1 got=%h exp=%h", {st1, ri1, fa1, rp1, tk1}, exp_vec(1)); end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL al_rise_count got=%0d exp=1", rises); end
    total++; if (st1[3] !== 1'b1) begin bad++; $display("FAIL al_state got=%b exp=1", st1[3]); end
  endtask

  task automatic test_simultaneous();
    bit found;
    found = 1'b0;
    pin0 = '0;
    for (int k = 0; k < 40; k++) begin
      step();
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL simul_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    total++; if (st0 !== '0) begin bad++; $display("FAIL simul_released got=%h exp=0", st0); end
    pin0 = '1;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (ri0 != 0) found = 1'b1;
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL simul_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
    end
    total++; if (ri0 !== 4'hF) begin bad++; $display("FAIL simul_rise got=%h exp=f", ri0); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int rises, first;
    found = 1'b0; rises = 0; first = -1;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (rp0[0]) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL mid_rpt got=none exp=pulse"); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({st0, ri0, fa0, rp0, tk0, st1, ri1, fa1, rp1, tk1} !== '0) begin
      bad++; $display("FAIL mid_async got=%h exp=0", {st0, ri0, fa0, rp0, tk0, st1, ri1, fa1, rp1, tk1});
    end
    model_reset();
    step(); step(); step();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ri0[0]) begin rises++; if (first < 0) first = k; end
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL mid_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
      total++; if ({st1, ri1, fa1, rp1, tk1} !== exp_vec(1)) begin bad++; $display("FAIL mid_model1 got=%h exp=%h", {st1, ri1, fa1, rp1, tk1}, exp_vec(1)); end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL mid_rise_count got=%0d exp=1", rises); end
    total++; if (first != DEPTH * DIV) begin bad++; $display("FAIL mid_rise_time got=%0d exp=%0d", first, DEPTH * DIV); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) pin0[c] = ~pin0[c];
        if ($urandom_range(0, 39) == 0) pin1[c] = ~pin1[c];
      end
      step();
      total++; if ({st0, ri0, fa0, rp0, tk0} !== exp_vec(0)) begin bad++; $display("FAIL random_model0 got=%h exp=%h", {st0, ri0, fa0, rp0, tk0}, exp_vec(0)); end
      total++; if ({st1, ri1, fa1, rp1, tk1} !== exp_vec(1)) begin bad++; $display("FAIL random_model1 got=%h exp=%h", {st1, ri1, fa1, rp1, tk1}, exp_vec(1)); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_active_low();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_debounce_multi.md
Name: pb_debounce_multi

Overview:
Multi-channel push-button debouncer. It is the parametrised successor of the single-channel 8-bit shift debouncer. Each channel has its own synchroniser, configurable-depth sample history, stable level, one-cycle rise/fall pulses and optional hold auto-repeat. It runs on the system clock with an internal sample-tick prescaler, so no separate slow clock is needed. It sits between board buttons/switches and the ALU/display control logic.

Parameters:
CHANNELS, 4, number of independent button inputs (1..16)
DEPTH, 8, consecutive equal samples required to change stable state (2..32)
DIV, 50000, clk cycles per sample tick (1 = sample every cycle)
ACTIVE_LOW, 0, 1 = raw input inverted before processing (pressed = 0 on pin)
REPEAT_DLY, 0, ticks held before first repeat pulse (0 = auto-repeat disabled)
REPEAT_PER, 100, ticks between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_in  input  CHANNELS  raw asynchronous button pins
btn_state  output  CHANNELS  debounced level, 1 = pressed
btn_rise  output  CHANNELS  one-clk pulse on press
btn_fall  output  CHANNELS  one-clk pulse on release
btn_rpt  output  CHANNELS  one-clk auto-repeat pulse while held
tick_out  output  1  sample tick, one clk wide (for benches and other users)

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
- Reset values:
  - all outputs 0
  - prescaler count 0
  - synchroniser flops and history at the not-pressed level, so no event fires on reset release
- Input path: raw XOR ACTIVE_LOW, then a 2-flop synchroniser per channel.
- Prescaler: counts 0..DIV-1 and wraps to 0. tick_out=1 for the single cycle where count==DIV-1. With DIV=1, tick_out is constantly 1.
- On a tick, each channel shifts its synchronised bit into a DEPTH-bit history.
- State update uses the post-shift history:
  - all ones and btn_state==0: btn_state<=1, btn_rise=1 for the next cycle only.
  - all zeros and btn_state==1: btn_state<=0, btn_fall=1 for the next cycle only.
  - mixed history: state is held, no pulse.
- Latency: btn_state and pulses change 1 clk after the qualifying tick. Worst case from a clean pin edge is 2 + DEPTH*DIV + 1 clk cycles.
- Auto-repeat (only when REPEAT_DLY>0), with a per-channel hold counter and limit register:
  - On the rise tick: counter <= 0, limit <= REPEAT_DLY.
  - On each later tick while btn_state==1: if counter+1 == limit, then btn_rpt pulses, counter <= 0 and limit <= REPEAT_PER; otherwise counter increments.
  - Example: with DLY=3, PER=2, repeats fire on ticks 3, 5, 7, ... after the rise tick.
- Counter widths come from clog2 of the largest operand. The counter never wraps beyond its limit.
- Release on a tick where a repeat would fire: fall wins, no btn_rpt. The counter clears on fall.
- btn_rise never coincides with btn_rpt. At most one of rise/fall/rpt is high per channel per cycle.
- Channels are fully independent, and simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation (including mid-pulse) clears everything immediately. No pulse is produced on reset deassertion even if a pin is held: the history must refill with DEPTH pressed samples first, then a normal rise fires.

Decomposition:
- Shared package: clog2 helper, and the default DIV constant for the 1 ms tick at the board clock.
- One sub-module, pb_debounce_chan: synchroniser, history, state, pulses and repeat for one channel, driven by the common tick.
- The top holds the prescaler and a generate loop over CHANNELS.

Test Plan (DIV=4, DEPTH=4, REPEAT_DLY=3, REPEAT_PER=2, CHANNELS=4 unless noted):
- Reset release with btn_in=0: all outputs 0. tick_out pulses every 4th clk, first at clk 3 after release.
- Clean press on ch0, pin held: btn_rise[0] is a single 1-clk pulse and btn_state[0]=1, both within 19 clk of the edge. Other channels stay 0.
- Bounce on ch1 (pin toggles every 5 clk for 40 clk, then stays 0): no rise/fall/rpt, btn_state[1] stays 0.
- Hold ch2 for 12 ticks: rise once, then btn_rpt[2] on ticks 3, 5, 7, 9, 11 after the rise tick. Release: one btn_fall pulse and no further rpt.
- ACTIVE_LOW=1, pins held at 1 through reset: no events. Drive ch3 to 0: rise occurs, and btn_state[3]=1 after DEPTH ticks.
- Assert rst_n=0 while ch0 is pressed and a repeat is pending: outputs are 0 asynchronously. After release of reset with the pin still held, the rise re-fires exactly once after 4 ticks.
